pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush controller for the five-stage integer pipeline. It sequences the PC, IF/ID, ID/EX and EX/MEM pipeline registers in four cases:
- inserting a bubble on load-use hazards;
- holding the ID/EX contents in EX for multi-cycle M-extension ops;
- freezing the pipe while data memory is busy;
- squashing wrong-path instructions on EX-resolved redirects.

It is the only source of the `stall`/`flush` inputs of the pipeline registers.

## Interface
- `MD_LATENCY`, default 4: EX residency in cycles of a mul/div op; legal range 1..32.
- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `id_rs1_addr` / `id_rs2_addr`  in  5 each  source registers of the instruction in ID.
- `id_rs1_re` / `id_rs2_re`  in  1 each  source register actually read.
- `ex_opcode`  in  7  opcode held in the ID/EX register.
- `ex_funct7`  in  7  funct7 held in the ID/EX register.
- `ex_rd_we`  in  1  rd write enable held in the ID/EX register.
- `ex_rd_addr`  in  5  rd address held in the ID/EX register.
- `ex_redirect`  in  1  branch/jump taken, resolved in EX.
- `mem_busy`  in  1  data memory not ready; MEM stage must hold.
- `pc_stall`  out  1  hold PC.
- `if_id_stall`  out  1  hold IF/ID.
- `if_id_flush`  out  1  clear IF/ID.
- `id_ex_stall`  out  1  hold ID/EX.
- `id_ex_flush`  out  1  clear ID/EX (bubble).
- `ex_mem_stall`  out  1  hold EX/MEM.
- `ex_mem_flush`  out  1  bubble into EX/MEM.
- `md_busy`  out  1  FSM in MD_WAIT.
- `stall_cycles`  out  32  saturating count of cycles with `pc_stall`=1.

## Operation
FSM states are RUN and MD_WAIT, with a 5-bit down-counter `md_cnt`. Priority, highest first: reset, mem wait, redirect, MD, load-use.
- **Reset:** `rst_n`=0 → state RUN, `md_cnt`=0, `stall_cycles`=0, all outputs 0 (outputs gated while reset is asserted).
- **Mem wait:** `mem_busy`=1 → `pc_stall`, `if_id_stall`, `id_ex_stall` and `ex_mem_stall` are all 1; every flush is 0; state and `md_cnt` are frozen; `ex_redirect` is deferred.
- **Redirect:** `ex_redirect`=1 with `mem_busy`=0 → `if_id_flush`=1 and `id_ex_flush`=1; `pc_stall`=0. This overrides a simultaneous load-use stall. `ex_redirect` is ignored in MD_WAIT.
- **MD op:** `ex_opcode`=0110011 and `ex_funct7`=0000001.
  - **Detect, in RUN with `MD_LATENCY`>1:** stall PC, IF/ID and ID/EX; `ex_mem_flush`=1; set `md_cnt` to `MD_LATENCY`-2; go to MD_WAIT.
  - **MD_WAIT with `md_cnt`≠0:** same stall/flush outputs; decrement `md_cnt`.
  - **MD_WAIT with `md_cnt`=0:** release all stalls (ID/EX advances); return to RUN.
  - **`MD_LATENCY`=1:** never stalls.
- **Load-use:** asserted when all of the following hold:
  - `ex_opcode`=0000011;
  - `ex_rd_we`=1;
  - `ex_rd_addr`≠0;
  - the rd address matches an enabled ID source register.
  
  Response: `pc_stall`=1, `if_id_stall`=1, `id_ex_flush`=1 for exactly one cycle. No state is needed, because the load leaves EX on the next edge.
- **`stall_cycles`:** increments by 1 on every edge where `pc_stall`=1. It holds at 0xFFFFFFFF once saturated.

## Timing
- All stall/flush outputs are combinational from the inputs, state and `md_cnt`, with no added latency. They are sampled by the pipeline registers on the same rising `clk` edge.
- State, `md_cnt` and `stall_cycles` update on the rising edge of `clk`, and asynchronously on the falling edge of `rst_n`.
- MD op: EX residency is exactly `MD_LATENCY` cycles, with `MD_LATENCY`-1 stall cycles. Cycles with `mem_busy`=1 extend this 1:1.
- Reset deasserted in MD_WAIT: the next cycle is in RUN with no stall.
- A load-use hazard whose consumer sits behind a `mem_busy` window produces its bubble in the first cycle after `mem_busy` falls.

## Structure
- Add to `defines.vh`:
  - `OPC_LOAD` (0000011);
  - `OPC_OP` (0110011);
  - `F7_MULDIV` (0000001);
  - state encodings `PC_ST_RUN` and `PC_ST_MDWAIT`.
- Sub-module `load_use_detect`: purely combinational address comparator. Inputs are the `id_*` and `ex_rd_*` signals plus `ex_opcode`; output is `hazard`.
- FSM, counter and output priority mux live in `pipeline_ctrl`.

## Test plan
- **Load-use:** `ex_opcode`=0000011, `ex_rd_addr`=5, `ex_rd_we`=1, `id_rs2_addr`=5, `id_rs2_re`=1 → one cycle of `pc_stall`=1, `if_id_stall`=1, `id_ex_flush`=1; `stall_cycles`=1. The same case with `ex_rd_addr`=0 gives no stall.
- **MD op, `MD_LATENCY`=4:** MD op enters ID/EX → 3 stall cycles with `ex_mem_flush`=1 and `md_busy`=1 in cycles 2–3; the fourth cycle releases; `stall_cycles`=3.
- **`mem_busy` during MD:** `mem_busy` high for 2 cycles mid-MD_WAIT → `md_cnt` frozen and all four stalls asserted; total MD residency is 6 cycles.
- **Redirect vs load-use:** `ex_redirect`=1 concurrent with a load-use match → `if_id_flush`=1, `id_ex_flush`=1, `pc_stall`=0. With `mem_busy`=1 as well, only the stalls are asserted until `mem_busy` falls.
- **Reset mid-operation:** `rst_n` pulled low in MD_WAIT → all outputs 0 immediately; after release, state is RUN and `stall_cycles`=0.
- **Saturation:** force `stall_cycles` to 0xFFFFFFFE, then hold a stall for 3 cycles → value stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared encodings and helpers for the pipeline stall/flush controller
//
// Purpose: opcode/funct7 constants, controller FSM state encoding and the
// bundle type for the seven stall/flush controls driven into the pipeline
// registers.
// Ports: none (package).

package pipeline_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic {
    PC_ST_RUN    = 1'b0,
    PC_ST_MDWAIT = 1'b1
  } pc_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic ex_mem_flush;
  } pipe_ctrl_t;

  // Register-register OP with the M-extension funct7 is a mul/div.
  function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPC_OP) && (funct7 == F7_MULDIV);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
//
// Purpose: flags when the load sitting in EX writes a register that the
// instruction in ID is about to read.
// Ports:
//   id_rs1_addr/id_rs2_addr  in  ID source register numbers
//   id_rs1_re/id_rs2_re      in  source register actually read
//   ex_opcode                in  opcode in the ID/EX register
//   ex_rd_we/ex_rd_addr      in  destination write enable / number in ID/EX
//   hazard                   out load-use hazard present

module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_re,
  input  logic       id_rs2_re,
  input  logic [6:0] ex_opcode,
  input  logic       ex_rd_we,
  input  logic [4:0] ex_rd_addr,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_re && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit = id_rs2_re && (id_rs2_addr == ex_rd_addr);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard = (ex_opcode == OPC_LOAD) && ex_rd_we && (ex_rd_addr != 5'd0)
                  && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush controller for the five-stage integer pipeline
//
// Purpose: sole driver of the stall/flush controls of the PC, IF/ID, ID/EX
// and EX/MEM registers. Handles memory wait, EX-resolved redirects,
// multi-cycle mul/div residency in EX and load-use bubbles, in that priority.
// Parameters:
//   MD_LATENCY  EX residency of a mul/div op in cycles (1..32)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_rs1_addr/id_rs2_addr    ID source registers
//   id_rs1_re/id_rs2_re        ID source register read enables
//   ex_opcode/ex_funct7        instruction fields held in ID/EX
//   ex_rd_we/ex_rd_addr        destination held in ID/EX
//   ex_redirect                taken branch/jump resolved in EX
//   mem_busy                   data memory not ready
//   pc_stall .. ex_mem_flush   pipeline register controls (combinational)
//   md_busy                    controller waiting out a mul/div
//   stall_cycles               saturating count of cycles with pc_stall

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_re,
  input  logic        id_rs2_re,
  input  logic [6:0]  ex_opcode,
  input  logic [6:0]  ex_funct7,
  input  logic        ex_rd_we,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_redirect,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        ex_mem_flush,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  // The detect cycle is one stall and the final MD_WAIT cycle releases, so
  // the counter only has to cover the MD_LATENCY-2 stalls in between.
  localparam bit         MD_STALLS   = (MD_LATENCY > 1);
  localparam logic [4:0] MD_CNT_INIT = MD_STALLS ? 5'(MD_LATENCY - 2) : 5'd0;

  pc_state_e   state_q;
  pc_state_e   state_d;
  logic [4:0]  md_cnt_q;
  logic [4:0]  md_cnt_d;
  pipe_ctrl_t  ctrl;
  logic        lu_hazard;
  logic        md_op;
  logic [31:0] stall_cycles_nxt;

  load_use_detect u_load_use_detect (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_re   (id_rs1_re),
    .id_rs2_re   (id_rs2_re),
    .ex_opcode   (ex_opcode),
    .ex_rd_we    (ex_rd_we),
    .ex_rd_addr  (ex_rd_addr),
    .hazard      (lu_hazard)
  );

  assign md_op = is_muldiv(ex_opcode, ex_funct7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PC_ST_RUN;
      md_cnt_q     <= 5'd0;
      stall_cycles <= 32'd0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      stall_cycles <= stall_cycles_nxt;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    ctrl     = '0;

    if (mem_busy) begin
      // Whole front of the pipe freezes; a pending redirect or hazard is
      // simply re-evaluated once memory is ready.
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
    end else if (state_q == PC_ST_MDWAIT) begin
      // A mul/div cannot redirect, so ex_redirect is not looked at here.
      if (md_cnt_q != 5'd0) begin
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_stall  = 1'b1;
        ctrl.id_ex_stall  = 1'b1;
        ctrl.ex_mem_flush = 1'b1;
        md_cnt_d          = md_cnt_q - 5'd1;
      end else begin
        state_d = PC_ST_RUN;
      end
    end else if (ex_redirect) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (md_op && MD_STALLS) begin
      // Keep the op in ID/EX and feed bubbles to MEM while it computes.
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_flush = 1'b1;
      md_cnt_d          = MD_CNT_INIT;
      state_d           = PC_ST_MDWAIT;
    end else if (lu_hazard) begin
      // The load moves on next edge, so a single bubble resolves it.
      ctrl.pc_stall    = 1'b1;
      ctrl.if_id_stall = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end
  end

  // Outputs are forced low for as long as reset is held.
  assign pc_stall     = rst_n & ctrl.pc_stall;
  assign if_id_stall  = rst_n & ctrl.if_id_stall;
  assign if_id_flush  = rst_n & ctrl.if_id_flush;
  assign id_ex_stall  = rst_n & ctrl.id_ex_stall;
  assign id_ex_flush  = rst_n & ctrl.id_ex_flush;
  assign ex_mem_stall = rst_n & ctrl.ex_mem_stall;
  assign ex_mem_flush = rst_n & ctrl.ex_mem_flush;
  assign md_busy      = rst_n & (state_q == PC_ST_MDWAIT);

  assign stall_cycles_nxt = (pc_stall && (stall_cycles != 32'hFFFF_FFFF))
                            ? stall_cycles + 32'd1 : stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl

module tb_pipeline_ctrl;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;

  // Expected control patterns, bit order {pc, if_id_s, if_id_f, id_ex_s, id_ex_f, ex_mem_s, ex_mem_f}
  localparam logic [6:0] P_NONE = 7'b0000000;
  localparam logic [6:0] P_BUSY = 7'b1101010;
  localparam logic [6:0] P_MD   = 7'b1101001;
  localparam logic [6:0] P_RDIR = 7'b0010100;
  localparam logic [6:0] P_LU   = 7'b1100100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_re, id_rs2_re, ex_rd_we, ex_redirect, mem_busy;
  logic [6:0]  ex_opcode, ex_funct7;

  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, ex_mem_flush, md_busy;
  logic [31:0] stall_cycles;
  logic        u1_pc_stall, u1_if_id_stall, u1_if_id_flush, u1_id_ex_stall, u1_id_ex_flush;
  logic        u1_ex_mem_stall, u1_ex_mem_flush, u1_md_busy;
  logic [31:0] u1_stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MD_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
    .ex_opcode(ex_opcode), .ex_funct7(ex_funct7),
    .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  pipeline_ctrl #(.MD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
    .ex_opcode(ex_opcode), .ex_funct7(ex_funct7),
    .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_stall(u1_pc_stall), .if_id_stall(u1_if_id_stall), .if_id_flush(u1_if_id_flush),
    .id_ex_stall(u1_id_ex_stall), .id_ex_flush(u1_id_ex_flush),
    .ex_mem_stall(u1_ex_mem_stall), .ex_mem_flush(u1_ex_mem_flush),
    .md_busy(u1_md_busy), .stall_cycles(u1_stall_cycles)
  );

  typedef struct packed {
    logic [4:0] rs1; logic re1; logic [4:0] rs2; logic re2;
    logic [6:0] opc; logic [6:0] f7; logic we; logic [4:0] rd;
    logic redir; logic busy;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [7:0] exp;   // {pattern, md_busy}, same for both latencies
  } vec_t;

  function automatic in_t mk(input logic [4:0] rs1, input logic re1, input logic [4:0] rs2,
                             input logic re2, input logic [6:0] opc, input logic [6:0] f7,
                             input logic we, input logic [4:0] rd, input logic redir,
                             input logic busy);
    in_t v;
    v.rs1 = rs1; v.re1 = re1; v.rs2 = rs2; v.re2 = re2; v.opc = opc; v.f7 = f7;
    v.we = we; v.rd = rd; v.redir = redir; v.busy = busy;
    return v;
  endfunction

  task automatic apply(input in_t v);
    id_rs1_addr = v.rs1; id_rs1_re = v.re1; id_rs2_addr = v.rs2; id_rs2_re = v.re2;
    ex_opcode = v.opc; ex_funct7 = v.f7; ex_rd_we = v.we; ex_rd_addr = v.rd;
    ex_redirect = v.redir; mem_busy = v.busy;
  endtask

  function automatic logic [7:0] got4();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
            ex_mem_stall, ex_mem_flush, md_busy};
  endfunction

  function automatic logic [7:0] got1();
    return {u1_pc_stall, u1_if_id_stall, u1_if_id_flush, u1_id_ex_stall, u1_id_ex_flush,
            u1_ex_mem_stall, u1_ex_mem_flush, u1_md_busy};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(mk(0, 0, 0, 0, OPC_IMM, 0, 0, 0, 0, 0));
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: an MD op occupies EX for `lat` ready (non-busy) cycles;
  // the pipe stalls on every ready cycle but the last one.
  task automatic model_step(input int lat, input bit act, input int age,
                            output logic [7:0] exp, output bit act_n, output int age_n);
    bit lu, md;
    int a;
    lu = (ex_opcode == OPC_LOAD) && ex_rd_we && (ex_rd_addr != 0) &&
         ((id_rs1_re && id_rs1_addr == ex_rd_addr) || (id_rs2_re && id_rs2_addr == ex_rd_addr));
    md = (ex_opcode == OPC_OP) && (ex_funct7 == 7'b0000001);
    act_n = act;
    age_n = age;
    exp   = {P_NONE, act};
    if (mem_busy) begin
      exp[7:1] = P_BUSY;
    end else if (act || (!ex_redirect && md)) begin
      a = act ? age : 0;
      if (a < lat - 1) begin
        exp[7:1] = P_MD;
        act_n = 1'b1;
        age_n = a + 1;
      end else begin
        act_n = 1'b0;
        age_n = 0;
      end
    end else if (ex_redirect) begin
      exp[7:1] = P_RDIR;
    end else if (lu) begin
      exp[7:1] = P_LU;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[12];
    in_t        idle, lu_in, md_in;
    logic [7:0] md_exp[6];
    logic [7:0] e4, e1;
    bit         a4, a1, na4, na1;
    int         g4, g1, ng4, ng1;
    logic [31:0] c4, c1;

    idle  = mk(0, 0, 0, 0, OPC_IMM, 0, 0, 0, 0, 0);
    lu_in = mk(0, 0, 5, 1, OPC_LOAD, 0, 1, 5, 0, 0);
    md_in = mk(1, 1, 2, 1, OPC_OP, 7'b0000001, 1, 7, 0, 0);

    tbl[0]  = '{idle, {P_NONE, 1'b0}};
    tbl[1]  = '{lu_in, {P_LU, 1'b0}};
    tbl[2]  = '{mk(0, 0, 5, 1, OPC_LOAD, 0, 1, 0, 0, 0), {P_NONE, 1'b0}};
    tbl[3]  = '{mk(0, 0, 0, 1, OPC_LOAD, 0, 1, 0, 0, 0), {P_NONE, 1'b0}};
    tbl[4]  = '{mk(9, 1, 3, 0, OPC_LOAD, 0, 1, 9, 0, 0), {P_LU, 1'b0}};
    tbl[5]  = '{mk(9, 0, 3, 1, OPC_LOAD, 0, 1, 9, 0, 0), {P_NONE, 1'b0}};
    tbl[6]  = '{mk(0, 0, 5, 1, OPC_LOAD, 0, 0, 5, 0, 0), {P_NONE, 1'b0}};
    tbl[7]  = '{mk(0, 0, 5, 1, OPC_OP, 0, 1, 5, 0, 0), {P_NONE, 1'b0}};
    tbl[8]  = '{mk(0, 0, 0, 0, OPC_IMM, 0, 0, 0, 1, 0), {P_RDIR, 1'b0}};
    tbl[9]  = '{mk(0, 0, 5, 1, OPC_LOAD, 0, 1, 5, 1, 0), {P_RDIR, 1'b0}};
    tbl[10] = '{mk(0, 0, 5, 1, OPC_LOAD, 0, 1, 5, 1, 1), {P_BUSY, 1'b0}};
    tbl[11] = '{mk(1, 1, 2, 1, OPC_OP, 7'b0000001, 1, 7, 0, 1), {P_BUSY, 1'b0}};

    // Reset state: outputs gated even with a hazard present.
    rst_n = 1'b0;
    apply(lu_in);
    #3;
    check("reset_outputs", got4(), 8'h00);
    check("reset_outputs_l1", got1(), 8'h00);
    check("reset_stall_cycles", stall_cycles, 32'd0);
    tick();
    rst_n = 1'b1;

    // Single-cycle vectors from RUN.
    foreach (tbl[i]) begin
      apply(tbl[i].in);
      #1;
      check($sformatf("vec%0d_l4", i), got4(), tbl[i].exp);
      check($sformatf("vec%0d_l1", i), got1(), tbl[i].exp);
      tick();
    end

    // Load-use: exactly one bubble, counted once.
    do_reset();
    apply(lu_in);
    #1;
    check("lu_bubble", got4(), {P_LU, 1'b0});
    tick();
    apply(idle);
    #1;
    check("lu_after", got4(), 8'h00);
    check("lu_count", stall_cycles, 32'd1);
    apply(mk(0, 0, 5, 1, OPC_LOAD, 0, 1, 0, 0, 0));
    #1;
    check("lu_x0", got4(), 8'h00);
    tick();
    check("lu_x0_count", stall_cycles, 32'd1);

    // MD op, latency 4: three stall cycles then release.
    do_reset();
    md_exp[0] = {P_MD, 1'b0};
    md_exp[1] = {P_MD, 1'b1};
    md_exp[2] = {P_MD, 1'b1};
    md_exp[3] = {P_NONE, 1'b1};
    apply(md_in);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("md_cyc%0d", k + 1), got4(), md_exp[k]);
      check($sformatf("md_l1_cyc%0d", k + 1), got1(), 8'h00);
      tick();
    end
    apply(idle);
    #1;
    check("md_after", got4(), 8'h00);
    check("md_count", stall_cycles, 32'd3);

    // mem_busy for two cycles inside MD_WAIT stretches residency to 6.
    do_reset();
    md_exp[0] = {P_MD, 1'b0};
    md_exp[1] = {P_MD, 1'b1};
    md_exp[2] = {P_BUSY, 1'b1};
    md_exp[3] = {P_BUSY, 1'b1};
    md_exp[4] = {P_MD, 1'b1};
    md_exp[5] = {P_NONE, 1'b1};
    for (int k = 0; k < 6; k++) begin
      apply(md_in);
      mem_busy = (k == 2 || k == 3);
      #1;
      check($sformatf("mdbusy_cyc%0d", k + 1), got4(), md_exp[k]);
      tick();
    end
    apply(idle);
    #1;
    check("mdbusy_after", got4(), 8'h00);
    check("mdbusy_count", stall_cycles, 32'd5);

    // Redirect + load-use behind mem_busy, then a load-use after busy falls.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      apply(mk(0, 0, 5, 1, OPC_LOAD, 0, 1, 5, 1, 1));
      #1;
      check($sformatf("rdir_busy%0d", k), got4(), {P_BUSY, 1'b0});
      tick();
    end
    apply(mk(0, 0, 5, 1, OPC_LOAD, 0, 1, 5, 1, 0));
    #1;
    check("rdir_released", got4(), {P_RDIR, 1'b0});
    tick();
    apply(mk(0, 0, 5, 1, OPC_LOAD, 0, 1, 5, 0, 1));
    #1;
    check("lu_behind_busy", got4(), {P_BUSY, 1'b0});
    tick();
    mem_busy = 1'b0;
    #1;
    check("lu_after_busy", got4(), {P_LU, 1'b0});
    tick();
    check("rdir_count", stall_cycles, 32'd4);

    // Reset pulled mid MD_WAIT.
    do_reset();
    apply(md_in);
    tick();
    #1;
    check("rst_mid_pre", got4(), {P_MD, 1'b1});
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", got4(), 8'h00);
    check("rst_mid_count", stall_cycles, 32'd0);
    apply(idle);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_rel_outputs", got4(), 8'h00);
    tick();
    check("rst_rel_run", got4(), 8'h00);
    check("rst_rel_count", stall_cycles, 32'd0);

    // Saturation: preload the counter just below full, then stall 3 cycles.
    do_reset();
    apply(idle);
    force dut.stall_cycles_nxt = 32'hFFFF_FFFE;
    tick();
    release dut.stall_cycles_nxt;
    #1;
    check("sat_preload", stall_cycles, 32'hFFFF_FFFE);
    mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("sat_hold%0d", k), stall_cycles, 32'hFFFF_FFFF);
    end
    mem_busy = 1'b0;

    // Randomized traffic against the reference model, both latencies.
    do_reset();
    a4 = 0; a1 = 0; g4 = 0; g1 = 0; c4 = 0; c1 = 0;
    for (int n = 0; n < 800; n++) begin
      int pick;
      pick = $urandom_range(0, 3);
      ex_opcode   = (pick == 0) ? OPC_LOAD : (pick == 3) ? 7'($urandom) : OPC_OP;
      ex_funct7   = ($urandom_range(0, 2) != 0) ? 7'b0000001 : 7'($urandom_range(0, 3) * 32);
      ex_rd_addr  = 5'($urandom_range(0, 3));
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      id_rs1_re   = 1'($urandom);
      id_rs2_re   = 1'($urandom);
      ex_rd_we    = 1'($urandom);
      ex_redirect = ($urandom_range(0, 6) == 0);
      mem_busy    = ($urandom_range(0, 4) == 0);
      #1;
      model_step(4, a4, g4, e4, na4, ng4);
      model_step(1, a1, g1, e1, na1, ng1);
      check($sformatf("rand%0d_l4", n), got4(), e4);
      check($sformatf("rand%0d_l1", n), got1(), e1);
      check($sformatf("rand%0d_cnt", n), stall_cycles, c4);
      check($sformatf("rand%0d_cnt_l1", n), u1_stall_cycles, c1);
      tick();
      a4 = na4; g4 = ng4; a1 = na1; g1 = ng1;
      if (e4[7] && c4 != 32'hFFFF_FFFF) c4 = c4 + 1;
      if (e1[7] && c1 != 32'hFFFF_FFFF) c1 = c1 + 1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
